// File: rtl/cp0_tlb_regs.sv
// MIPS CP0 register file covering the TLB, exception and interrupt registers.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_tlb_regs #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [4:0]      ex_code,
  input  logic            ex_bd,
  input  logic [31:0]     ex_pc,
  input  logic [31:0]     ex_badvaddr,
  input  logic            eret,
  input  logic [5:0]      hw_int,
  input  logic            mtc0_we,
  input  logic [4:0]      mtc0_addr,
  input  logic [31:0]     mtc0_wdata,
  input  logic [4:0]      raddr,
  output logic [31:0]     rdata,
  input  logic            tlbp,
  input  logic            tlbr,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  input  logic [18:0]     r_vpn2,
  input  logic [7:0]      r_asid,
  input  logic            r_g,
  input  logic [19:0]     r_pfn0,
  input  logic [2:0]      r_c0,
  input  logic            r_d0,
  input  logic            r_v0,
  input  logic [19:0]     r_pfn1,
  input  logic [2:0]      r_c1,
  input  logic            r_d1,
  input  logic            r_v1,
  output logic [IDXW-1:0] w_index,
  output logic [IDXW-1:0] wr_index,
  output logic [31:0]     entryhi,
  output logic [31:0]     entrylo0,
  output logic [31:0]     entrylo1,
  output logic [31:0]     epc,
  output logic            int_req
);
  localparam logic [4:0] A_INDEX = 5'd0,  A_RANDOM = 5'd1,  A_LO0 = 5'd2,   A_LO1 = 5'd3;
  localparam logic [4:0] A_WIRED = 5'd6,  A_BVA    = 5'd8,  A_COUNT = 5'd9, A_EHI = 5'd10;
  localparam logic [4:0] A_CMP   = 5'd11, A_STATUS = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;
  localparam logic [IDXW-1:0] MAXIDX = IDXW'(TLBNUM - 1);

  logic            index_p_q, index_p_d;
  logic [IDXW-1:0] index_q, index_d, random_q, random_d, wired_q, wired_d;
  logic [18:0]     vpn2_q, vpn2_d;
  logic [7:0]      asid_q, asid_d;
  logic [19:0]     pfn0_q, pfn0_d, pfn1_q, pfn1_d;
  logic [2:0]      c0_q, c0_d, c1_q, c1_d;
  logic            d0_q, d0_d, v0_q, v0_d, g0_q, g0_d;
  logic            d1_q, d1_d, v1_q, v1_d, g1_q, g1_d;
  logic [31:0]     badvaddr_q, badvaddr_d, epc_q, epc_d;
  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]      exccode_q, exccode_d;
  logic [5:0]      ip_hw_q, ip_hw_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic            ti;
  logic [31:0]     count_rd, compare_rd;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        ti_q, ti_d, half_q, half_d;
  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  logic [7:0] ip;
  assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  // Fields are assigned lowest priority first so later writers override.
  always_comb begin
    index_p_d = index_p_q; index_d = index_q; wired_d = wired_q;
    random_d  = (random_q == wired_q) ? MAXIDX : random_q - 1'b1;
    vpn2_d = vpn2_q; asid_d = asid_q;
    pfn0_d = pfn0_q; c0_d = c0_q; d0_d = d0_q; v0_d = v0_q; g0_d = g0_q;
    pfn1_d = pfn1_q; c1_d = c1_q; d1_d = d1_q; v1_d = v1_q; g1_d = g1_q;
    badvaddr_d = badvaddr_q; epc_d = epc_q;
    im_d = im_q; exl_d = exl_q; ie_d = ie_q; bd_d = bd_q; exccode_d = exccode_q;
    ip_hw_d = hw_int; ip_sw_d = ip_sw_q;
`ifdef CP0_TIMER_EN
    half_d    = ~half_q;
    count_d   = half_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
`endif
    if (mtc0_we) begin
      case (mtc0_addr)
        A_INDEX: index_d = mtc0_wdata[IDXW-1:0];
        A_LO0: begin
          pfn0_d = mtc0_wdata[25:6]; c0_d = mtc0_wdata[5:3];
          d0_d = mtc0_wdata[2]; v0_d = mtc0_wdata[1]; g0_d = mtc0_wdata[0];
        end
        A_LO1: begin
          pfn1_d = mtc0_wdata[25:6]; c1_d = mtc0_wdata[5:3];
          d1_d = mtc0_wdata[2]; v1_d = mtc0_wdata[1]; g1_d = mtc0_wdata[0];
        end
        A_WIRED: begin
          wired_d  = mtc0_wdata[IDXW-1:0];
          random_d = MAXIDX;
        end
        A_EHI: begin
          vpn2_d = mtc0_wdata[31:13]; asid_d = mtc0_wdata[7:0];
        end
        A_STATUS: begin
          im_d = mtc0_wdata[15:8]; exl_d = mtc0_wdata[1]; ie_d = mtc0_wdata[0];
        end
        A_CAUSE: ip_sw_d = mtc0_wdata[9:8];
        A_EPC:   epc_d = mtc0_wdata;
`ifdef CP0_TIMER_EN
        A_COUNT: count_d = mtc0_wdata;
        A_CMP: begin
          compare_d = mtc0_wdata;
          ti_d      = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    if (tlbp) begin
      index_p_d = ~s_found;
      if (s_found) index_d = s_index;
    end
    if (tlbr) begin
      vpn2_d = r_vpn2; asid_d = r_asid;
      pfn0_d = r_pfn0; c0_d = r_c0; d0_d = r_d0; v0_d = r_v0; g0_d = r_g;
      pfn1_d = r_pfn1; c1_d = r_c1; d1_d = r_d1; v1_d = r_v1; g1_d = r_g;
    end
    if (eret) exl_d = 1'b0;
    if (ex_valid) begin
      exccode_d = ex_code;
      exl_d     = 1'b1;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = ex_bd ? ex_pc - 32'd4 : ex_pc;
        bd_d  = ex_bd;
      end
      if (ex_code inside {[5'd1:5'd5]}) badvaddr_d = ex_badvaddr;
      if (ex_code inside {[5'd1:5'd3]}) vpn2_d = ex_badvaddr[31:13];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_p_q <= 1'b0; index_q <= '0; random_q <= MAXIDX; wired_q <= '0;
      vpn2_q <= '0; asid_q <= '0;
      pfn0_q <= '0; c0_q <= '0; d0_q <= 1'b0; v0_q <= 1'b0; g0_q <= 1'b0;
      pfn1_q <= '0; c1_q <= '0; d1_q <= 1'b0; v1_q <= 1'b0; g1_q <= 1'b0;
      badvaddr_q <= '0; epc_q <= '0;
      im_q <= '0; exl_q <= 1'b0; ie_q <= 1'b0; bd_q <= 1'b0; exccode_q <= '0;
      ip_hw_q <= '0; ip_sw_q <= '0;
`ifdef CP0_TIMER_EN
      count_q <= '0; compare_q <= '0; ti_q <= 1'b0; half_q <= 1'b0;
`endif
    end else begin
      index_p_q <= index_p_d; index_q <= index_d; random_q <= random_d; wired_q <= wired_d;
      vpn2_q <= vpn2_d; asid_q <= asid_d;
      pfn0_q <= pfn0_d; c0_q <= c0_d; d0_q <= d0_d; v0_q <= v0_d; g0_q <= g0_d;
      pfn1_q <= pfn1_d; c1_q <= c1_d; d1_q <= d1_d; v1_q <= v1_d; g1_q <= g1_d;
      badvaddr_q <= badvaddr_d; epc_q <= epc_d;
      im_q <= im_d; exl_q <= exl_d; ie_q <= ie_d; bd_q <= bd_d; exccode_q <= exccode_d;
      ip_hw_q <= ip_hw_d; ip_sw_q <= ip_sw_d;
`ifdef CP0_TIMER_EN
      count_q <= count_d; compare_q <= compare_d; ti_q <= ti_d; half_q <= half_d;
`endif
    end
  end

  assign w_index  = index_q;
  assign wr_index = random_q;
  assign entryhi  = {vpn2_q, 5'b0, asid_q};
  assign entrylo0 = {6'b0, pfn0_q, c0_q, d0_q, v0_q, g0_q};
  assign entrylo1 = {6'b0, pfn1_q, c1_q, d1_q, v1_q, g1_q};
  assign epc      = epc_q;
  assign int_req  = ie_q & ~exl_q & |(ip & im_q);

  always_comb begin
    rdata = '0;
    case (raddr)
      A_INDEX:  rdata = {index_p_q, {(31-IDXW){1'b0}}, index_q};
      A_RANDOM: rdata = {{(32-IDXW){1'b0}}, random_q};
      A_LO0:    rdata = entrylo0;
      A_LO1:    rdata = entrylo1;
      A_WIRED:  rdata = {{(32-IDXW){1'b0}}, wired_q};
      A_BVA:    rdata = badvaddr_q;
      A_COUNT:  rdata = count_rd;
      A_EHI:    rdata = entryhi;
      A_CMP:    rdata = compare_rd;
      A_STATUS: rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      A_CAUSE:  rdata = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
      A_EPC:    rdata = epc_q;
      default:  rdata = '0;
    endcase
  end
endmodule
